// File: rtl/xpb_seg_accumulator_pkg.sv
// Shared constants and FSM encoding for the xpb segment accumulator.
package xpb_seg_accumulator_pkg;

  localparam int unsigned DEF_WIDTH    = 1024;
  localparam int unsigned DEF_SEG_BITS = 5;
  localparam int unsigned DEF_NUM_SEG  = 8;
  localparam int unsigned DEF_LUT_LAT  = 1;
  localparam int unsigned DEF_GUARD    = 8;

  // Select width, kept at least one bit so a single-segment build still has a port
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_SEL_W = sel_width(DEF_NUM_SEG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/xpb_seg_accumulator_if.sv
// Request, table-lookup and result signals between the squarer datapath and the accumulator.
interface xpb_seg_accumulator_if
  import xpb_seg_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned SEG_BITS = DEF_SEG_BITS,
  parameter int unsigned NUM_SEG  = DEF_NUM_SEG,
  parameter int unsigned GUARD    = DEF_GUARD
);
  localparam int unsigned SEL_W = sel_width(NUM_SEG);
  localparam int unsigned HI_W  = NUM_SEG * SEG_BITS;

  logic                   start;
  logic [HI_W-1:0]        hi_in;
  logic [WIDTH-1:0]       lo_in;
  logic                   busy;
  logic                   seg_valid;
  logic [SEL_W-1:0]       seg_sel;
  logic [SEG_BITS-1:0]    seg_data;
  logic [WIDTH-1:0]       lut_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH+GUARD-1:0] sum_out;

  modport master (
    output start, hi_in, lo_in, lut_data, out_ready,
    input  busy, seg_valid, seg_sel, seg_data, out_valid, sum_out
  );

  modport slave (
    input  start, hi_in, lo_in, lut_data, out_ready,
    output busy, seg_valid, seg_sel, seg_data, out_valid, sum_out
  );

endinterface

// File: rtl/xpb_vld_pipe.sv
// Single-bit delay line matching the table read latency; flags when nothing is queued
// behind the output stage, i.e. the line is empty after the next edge if vld_in stays low.
module xpb_vld_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld_in,
  output logic vld_out,
  output logic empty
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  generate
    if (DEPTH == 1) begin : g_single
      always_comb pipe_d = vld_in;
      assign empty = 1'b1;
    end else begin : g_multi
      always_comb pipe_d = {pipe_q[DEPTH-2:0], vld_in};
      assign empty = ~|pipe_q[DEPTH-2:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign vld_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/xpb_seg_accumulator.sv
// Issues one xpb table lookup per upper-product segment and sums the returned
// residues onto the low product part; result held until the consumer takes it.
module xpb_seg_accumulator
  import xpb_seg_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned SEG_BITS = DEF_SEG_BITS,
  parameter int unsigned NUM_SEG  = DEF_NUM_SEG,
  parameter int unsigned LUT_LAT  = DEF_LUT_LAT,
  parameter int unsigned GUARD    = DEF_GUARD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  xpb_seg_accumulator_if.slave bus
);

  localparam int unsigned SEL_W = sel_width(NUM_SEG);
  localparam int unsigned HI_W  = NUM_SEG * SEG_BITS;
  localparam int unsigned ACC_W = WIDTH + GUARD;

  state_e              state_q, state_d;
  logic [HI_W-1:0]     shift_q, shift_d;
  logic [SEL_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                busy_q, busy_d;
  logic                seg_valid_q, seg_valid_d;
  logic [SEL_W-1:0]    seg_sel_q, seg_sel_d;
  logic [SEG_BITS-1:0] seg_data_q, seg_data_d;
  logic                out_valid_q, out_valid_d;
  logic [ACC_W-1:0]    sum_out_q, sum_out_d;

  logic lut_vld;
  logic lut_tail_empty;

  xpb_vld_pipe #(
    .DEPTH (LUT_LAT)
  ) u_vld_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_in  (seg_valid_q),
    .vld_out (lut_vld),
    .empty   (lut_tail_empty)
  );

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sum_out_d = sum_out_q;

    if (lut_vld) acc_d = acc_q + ACC_W'(bus.lut_data);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          shift_d = bus.hi_in;
          cnt_d   = '0;
          acc_d   = ACC_W'(bus.lo_in);
        end
      end
      ISSUE: begin
        shift_d = shift_q >> SEG_BITS;
        cnt_d   = cnt_q + SEL_W'(1);
        if (cnt_q == SEL_W'(NUM_SEG - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        // The add retiring on this edge is the last one once nothing trails it
        if (lut_tail_empty) begin
          state_d   = DONE;
          sum_out_d = acc_d;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    seg_valid_d = (state_d == ISSUE);
    seg_sel_d   = seg_valid_d ? cnt_d : '0;
    seg_data_d  = seg_valid_d ? shift_d[SEG_BITS-1:0] : '0;
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      seg_valid_q <= 1'b0;
      seg_sel_q   <= '0;
      seg_data_q  <= '0;
      out_valid_q <= 1'b0;
      sum_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      seg_valid_q <= seg_valid_d;
      seg_sel_q   <= seg_sel_d;
      seg_data_q  <= seg_data_d;
      out_valid_q <= out_valid_d;
      sum_out_q   <= sum_out_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.seg_valid = seg_valid_q;
  assign bus.seg_sel   = seg_sel_q;
  assign bus.seg_data  = seg_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum_out   = sum_out_q;

endmodule
